// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety-island boot and control logic.
package safety_island_pkg;

  typedef enum logic [1:0] {
    Jtag      = 2'b00,
    Preloaded = 2'b01
  } bootmode_e;

  localparam logic [31:0] BootROMAddrOffset = 32'h0000_1000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_ENTRY = 3'd1,
    START      = 3'd2,
    RUN        = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } boot_state_e;

endpackage

// File: rtl/safety_island_boot_timer.sv
// Saturating 32-bit cycle counter that flags when Limit cycles have been spent
// counting since the last clear.
module safety_island_boot_timer #(
  parameter logic [31:0] Limit = 32'd1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count holds Limit-1 during the Limit-th enabled cycle after a clear.
  assign expired_o = (count_q >= (Limit - 32'd1));

endmodule

// File: rtl/safety_island_boot_ctrl.sv
// Safety-island core start-up sequencer: picks the boot address from the
// bootmode, gates core fetch enable and tracks end-of-computation.
module safety_island_boot_ctrl
  import safety_island_pkg::*;
#(
  parameter logic [31:0] BaseAddr          = 32'h6000_0000,
  parameter logic [31:0] BootTimeoutCycles = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  bootmode_i,
  input  logic        fetch_en_i,
  input  logic [31:0] entry_addr_i,
  input  logic        entry_valid_i,
  input  logic        eoc_i,
  output logic        core_fetch_en_o,
  output logic [31:0] core_boot_addr_o,
  output logic [2:0]  state_o,
  output logic        boot_err_o,
  output logic        eoc_o
);

  localparam logic [31:0] RomAddr = BaseAddr + BootROMAddrOffset;

  boot_state_e state_q;
  bootmode_e   mode_q;
  logic        fetch_en_q;
  logic [31:0] boot_addr_q;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;
  logic        entry_aligned;

  assign timer_clear   = (state_q == IDLE);
  assign timer_en      = (state_q == WAIT_ENTRY);
  assign entry_aligned = (entry_addr_i[1:0] == 2'b00);

  safety_island_boot_timer #(
    .Limit(BootTimeoutCycles)
  ) u_boot_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expired_o(timer_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mode_q      <= Jtag;
      fetch_en_q  <= 1'b0;
      boot_addr_q <= RomAddr;
    end else if ((state_q != IDLE) && !fetch_en_i) begin
      // Abort wins over everything; the boot address is deliberately kept.
      state_q    <= IDLE;
      fetch_en_q <= 1'b0;
    end else begin
      // Fetch enable trails the RUN entry by one cycle so the address settles first.
      fetch_en_q <= (state_q == RUN) || (state_q == DONE);
      case (state_q)
        IDLE: begin
          mode_q <= bootmode_e'(bootmode_i);
          if (fetch_en_i) begin
            case (bootmode_i)
              Jtag: begin
                state_q     <= START;
                boot_addr_q <= RomAddr;
              end
              Preloaded: state_q <= WAIT_ENTRY;
              default:   state_q <= ERROR;
            endcase
          end
        end
        WAIT_ENTRY: begin
          if (entry_valid_i && (mode_q == Preloaded)) begin
            if (entry_aligned) begin
              state_q     <= START;
              boot_addr_q <= entry_addr_i;
            end else begin
              state_q <= ERROR;
            end
          end else if (timer_expired) begin
            state_q <= ERROR;
          end
        end
        START: state_q <= RUN;
        RUN: begin
          if (eoc_i) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= DONE;
        ERROR:   state_q <= ERROR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_fetch_en_o  = fetch_en_q;
  assign core_boot_addr_o = boot_addr_q;
  assign state_o          = state_q;
  assign boot_err_o       = (state_q == ERROR);
  assign eoc_o            = (state_q == DONE);

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Directed and randomized bench for safety_island_boot_ctrl against a
// cycle-level behavioural model of the boot sequence.
module tb_safety_island_boot_ctrl;

  localparam logic [31:0] ROM     = 32'h6000_1000;
  localparam int          TIMEOUT = 16;
  localparam int S_IDLE = 0, S_WAIT = 1, S_START = 2, S_RUN = 3, S_DONE = 4, S_ERR = 5;

  logic        clk;
  logic        rst_n;
  logic [1:0]  bootmode;
  logic        fetch_en;
  logic [31:0] entry_addr;
  logic        entry_valid;
  logic        eoc;
  logic        core_fetch_en;
  logic [31:0] core_boot_addr;
  logic [2:0]  state;
  logic        boot_err;
  logic        eoc_out;

  int errors = 0;
  int checks = 0;

  safety_island_boot_ctrl #(
    .BaseAddr         (32'h6000_0000),
    .BootTimeoutCycles(32'd16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .bootmode_i      (bootmode),
    .fetch_en_i      (fetch_en),
    .entry_addr_i    (entry_addr),
    .entry_valid_i   (entry_valid),
    .eoc_i           (eoc),
    .core_fetch_en_o (core_fetch_en),
    .core_boot_addr_o(core_boot_addr),
    .state_o         (state),
    .boot_err_o      (boot_err),
    .eoc_o           (eoc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: which phase the boot is in, when waiting began, and
  // whether the core was already running on the previous cycle.
  int          m_state = S_IDLE;
  logic        m_fetch = 1'b0;
  logic [31:0] m_addr  = ROM;
  bit          m_live  = 1'b0;
  int          edge_n  = 0;
  int          wait_start = 0;

  always @(posedge clk) begin
    int prev;
    edge_n++;
    if (!rst_n) begin
      m_state = S_IDLE;
      m_fetch = 1'b0;
      m_addr  = ROM;
      m_live  = 1'b1;
    end else begin
      prev = m_state;
      if (prev != S_IDLE && !fetch_en) begin
        m_state = S_IDLE;
      end else if (prev == S_IDLE) begin
        if (fetch_en) begin
          if (bootmode == 2'd0) begin
            m_state = S_START;
            m_addr  = ROM;
          end else if (bootmode == 2'd1) begin
            m_state    = S_WAIT;
            wait_start = edge_n;
          end else begin
            m_state = S_ERR;
          end
        end
      end else if (prev == S_WAIT) begin
        if (entry_valid) begin
          if (entry_addr % 4 == 0) begin
            m_state = S_START;
            m_addr  = entry_addr;
          end else begin
            m_state = S_ERR;
          end
        end else if (edge_n - wait_start >= TIMEOUT) begin
          m_state = S_ERR;
        end
      end else if (prev == S_START) begin
        m_state = S_RUN;
      end else if (prev == S_RUN && eoc) begin
        m_state = S_DONE;
      end
      m_fetch = (prev == S_RUN || prev == S_DONE) && (m_state != S_IDLE);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("state_o", 32'(state), 32'(m_state));
      chk("core_fetch_en_o", 32'(core_fetch_en), 32'(m_fetch));
      chk("core_boot_addr_o", core_boot_addr, m_addr);
      chk("boot_err_o", 32'(boot_err), 32'(m_state == S_ERR));
      chk("eoc_o", 32'(eoc_out), 32'(m_state == S_DONE));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic lit(input string tag, input int st, input logic fe, input logic [31:0] addr,
                     input logic err, input logic eo);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".fetch_en"}, 32'(core_fetch_en), 32'(fe));
    chk({tag, ".boot_addr"}, core_boot_addr, addr);
    chk({tag, ".err"}, 32'(boot_err), 32'(err));
    chk({tag, ".eoc"}, 32'(eoc_out), 32'(eo));
    $display("txn %s: state=%0d fetch_en=%0b addr=%h err=%0b eoc=%0b", tag, state,
             core_fetch_en, core_boot_addr, boot_err, eoc_out);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; bootmode = 2'd0; fetch_en = 1'b0;
    entry_addr = '0; entry_valid = 1'b0; eoc = 1'b0;
    @(negedge clk);
    cyc(2);
    lit("reset", S_IDLE, 1'b0, ROM, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1);

    // Jtag boot: fetch enable reaches the core three edges after the request.
    bootmode = 2'd0; fetch_en = 1'b1;
    cyc(1); lit("jtag_c1", S_START, 1'b0, ROM, 1'b0, 1'b0);
    cyc(1); lit("jtag_c2", S_RUN, 1'b0, ROM, 1'b0, 1'b0);
    cyc(1); lit("jtag_c3", S_RUN, 1'b1, ROM, 1'b0, 1'b0);

    // End of computation is sticky; a second pulse changes nothing.
    eoc = 1'b1; cyc(1); eoc = 1'b0;
    lit("eoc", S_DONE, 1'b1, ROM, 1'b0, 1'b1);
    cyc(2); eoc = 1'b1; cyc(1); eoc = 1'b0;
    lit("eoc_sticky", S_DONE, 1'b1, ROM, 1'b0, 1'b1);
    fetch_en = 1'b0; cyc(1);
    lit("abort_done", S_IDLE, 1'b0, ROM, 1'b0, 1'b0);

    // Preloaded boot with entry point delivered in the tenth cycle.
    bootmode = 2'd1; fetch_en = 1'b1; cyc(1);
    lit("pre_wait", S_WAIT, 1'b0, ROM, 1'b0, 1'b0);
    cyc(9);
    entry_addr = 32'h6001_0080; entry_valid = 1'b1; cyc(1); entry_valid = 1'b0;
    lit("pre_start", S_START, 1'b0, 32'h6001_0080, 1'b0, 1'b0);
    cyc(2);
    lit("pre_run", S_RUN, 1'b1, 32'h6001_0080, 1'b0, 1'b0);
    fetch_en = 1'b0; cyc(1);
    lit("pre_abort", S_IDLE, 1'b0, 32'h6001_0080, 1'b0, 1'b0);

    // Timeout: 16 cycles in WAIT_ENTRY without an entry point.
    fetch_en = 1'b1; cyc(1); cyc(15);
    lit("to_c16", S_WAIT, 1'b0, 32'h6001_0080, 1'b0, 1'b0);
    cyc(1);
    lit("timeout", S_ERR, 1'b0, 32'h6001_0080, 1'b1, 1'b0);
    fetch_en = 1'b0; cyc(1);
    lit("err_clear", S_IDLE, 1'b0, 32'h6001_0080, 1'b0, 1'b0);

    // Entry point arriving on the timeout cycle still boots.
    fetch_en = 1'b1; cyc(16);
    entry_addr = 32'h6001_0100; entry_valid = 1'b1; cyc(1); entry_valid = 1'b0;
    lit("to_valid", S_START, 1'b0, 32'h6001_0100, 1'b0, 1'b0);
    fetch_en = 1'b0; cyc(1);

    // Reserved bootmodes and a misaligned entry point both fail.
    bootmode = 2'd3; fetch_en = 1'b1; cyc(1);
    lit("mode3", S_ERR, 1'b0, 32'h6001_0100, 1'b1, 1'b0);
    fetch_en = 1'b0; cyc(1);
    bootmode = 2'd2; fetch_en = 1'b1; cyc(1);
    lit("mode2", S_ERR, 1'b0, 32'h6001_0100, 1'b1, 1'b0);
    fetch_en = 1'b0; cyc(1);
    bootmode = 2'd1; fetch_en = 1'b1; cyc(3);
    entry_addr = 32'h6001_0082; entry_valid = 1'b1; cyc(1); entry_valid = 1'b0;
    lit("misalign", S_ERR, 1'b0, 32'h6001_0100, 1'b1, 1'b0);
    fetch_en = 1'b0; cyc(1);

    // Reset in RUN; a bootmode change while running is ignored.
    bootmode = 2'd0; fetch_en = 1'b1; cyc(3);
    bootmode = 2'd3; cyc(2);
    lit("run_mode_chg", S_RUN, 1'b1, ROM, 1'b0, 1'b0);
    rst_n = 1'b0; fetch_en = 1'b0; cyc(1);
    lit("mid_reset", S_IDLE, 1'b0, ROM, 1'b0, 1'b0);
    rst_n = 1'b1; cyc(1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (fetch_en) fetch_en = ($urandom_range(0, 39) != 0);
      else          fetch_en = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      bootmode = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : 2'($urandom_range(2, 3));
      entry_valid = ($urandom_range(0, 11) == 0);
      entry_addr  = $urandom();
      if ($urandom_range(0, 4) != 0) entry_addr[1:0] = 2'b00;
      eoc = ($urandom_range(0, 9) == 0);
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
